// File: rtl/sample_voice_addr_gen_if.sv
// Bus between the key/gate decoder (master) and the multi-voice sample
// address generator (slave).
//   sample_tick    : one-cycle strobe at the audio sample rate
//   gate_in        : per-voice gate (key held)
//   mode_in        : per-voice mode, 0 = loop, 1 = one-shot
//   step_in        : per-voice phase increment, voice v at [v*STEP_WIDTH +: STEP_WIDTH]
//   loop_start_in  : shared loop window start
//   loop_end_in    : shared loop window end (inclusive)
//   sample_addr    : per-voice BRAM read address, voice v at [v*ADDR_WIDTH +: ADDR_WIDTH]
//   active_out     : voice is playing
//   done_pulse_out : one-cycle pulse when a one-shot voice finishes
//   led            : any voice active
interface sample_voice_addr_gen_if #(
    parameter int NUM_VOICES = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int STEP_WIDTH = 21
);
    logic                             sample_tick;
    logic [NUM_VOICES-1:0]            gate_in;
    logic [NUM_VOICES-1:0]            mode_in;
    logic [NUM_VOICES*STEP_WIDTH-1:0] step_in;
    logic [ADDR_WIDTH-1:0]            loop_start_in;
    logic [ADDR_WIDTH-1:0]            loop_end_in;
    logic [NUM_VOICES*ADDR_WIDTH-1:0] sample_addr;
    logic [NUM_VOICES-1:0]            active_out;
    logic [NUM_VOICES-1:0]            done_pulse_out;
    logic                             led;

    modport master (
        output sample_tick, gate_in, mode_in, step_in, loop_start_in, loop_end_in,
        input  sample_addr, active_out, done_pulse_out, led
    );

    modport slave (
        input  sample_tick, gate_in, mode_in, step_in, loop_start_in, loop_end_in,
        output sample_addr, active_out, done_pulse_out, led
    );
endinterface

// File: rtl/sample_voice_addr_gen.sv
// Multi-voice sample address generator. Each voice keeps a fixed-point phase
// accumulator (integer address . FRAC_WIDTH fraction) that advances by its own
// step on every sample_tick while the voice plays, wrapping inside a shared
// loop window (loop mode) or stopping at its end (one-shot mode).
// Ports:
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   bus    : slave side of sample_voice_addr_gen_if (gates, modes, steps,
//            loop window in; addresses, activity, done pulses, led out)
module sample_voice_addr_gen #(
    parameter int NUM_VOICES = 8,
    parameter int BRAM_DEPTH = 8192,
    parameter int ADDR_WIDTH = 13,
    parameter int FRAC_WIDTH = 8,
    parameter int STEP_WIDTH = ADDR_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    sample_voice_addr_gen_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_LAST = (ADDR_WIDTH + 1)'(BRAM_DEPTH - 1);
    localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO  = {FRAC_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } voice_state_t;

    voice_state_t                      state_r [NUM_VOICES];
    logic [STEP_WIDTH-1:0]             phase_r [NUM_VOICES];
    logic [NUM_VOICES-1:0]             gate_prev_r;
    logic [NUM_VOICES*ADDR_WIDTH-1:0]  sample_addr_r;
    logic [NUM_VOICES-1:0]             active_r;
    logic [NUM_VOICES-1:0]             done_pulse_r;
    logic                              led_r;

    logic [ADDR_WIDTH-1:0]             win_start_s;
    logic [ADDR_WIDTH-1:0]             win_end_s;
    // One extra carry bit so a large step past the top of the BRAM is still
    // seen as an overshoot rather than wrapping to a small address.
    logic [STEP_WIDTH:0]               sum_s [NUM_VOICES];
    logic [NUM_VOICES-1:0]             rise_s;
    logic [NUM_VOICES-1:0]             overshoot_s;
    logic [NUM_VOICES-1:0]             active_next_s;

    // Clamp the shared window to the BRAM; an inverted window collapses onto its end.
    always_comb begin
        if ({1'b0, bus.loop_end_in} > DEPTH_LAST) begin
            win_end_s = DEPTH_LAST[ADDR_WIDTH-1:0];
        end else begin
            win_end_s = bus.loop_end_in;
        end
        if (bus.loop_start_in > win_end_s) begin
            win_start_s = win_end_s;
        end else begin
            win_start_s = bus.loop_start_in;
        end
    end

    // Per-voice phase sum, gate rising edge and the activity the next edge will produce.
    always_comb begin
        sum_s         = '{default: {(STEP_WIDTH + 1){1'b0}}};
        rise_s        = {NUM_VOICES{1'b0}};
        overshoot_s   = {NUM_VOICES{1'b0}};
        active_next_s = {NUM_VOICES{1'b0}};
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum_s[v]       = {1'b0, phase_r[v]} + {1'b0, bus.step_in[v*STEP_WIDTH +: STEP_WIDTH]};
            rise_s[v]      = bus.gate_in[v] & ~gate_prev_r[v];
            overshoot_s[v] = (sum_s[v][STEP_WIDTH:FRAC_WIDTH] > {1'b0, win_end_s});
            if (!bus.gate_in[v]) begin
                active_next_s[v] = 1'b0;
            end else if (rise_s[v]) begin
                active_next_s[v] = 1'b1;
            end else if (state_r[v] == ST_PLAY) begin
                // Only a one-shot overshoot on a tick ends the note.
                active_next_s[v] = ~(bus.sample_tick & overshoot_s[v] & bus.mode_in[v]);
            end else begin
                active_next_s[v] = 1'b0;
            end
        end
    end

    // Per-voice IDLE/PLAY/DONE sequencing with registered address, status and led.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_r[v] <= ST_IDLE;
                phase_r[v] <= {STEP_WIDTH{1'b0}};
            end
            gate_prev_r   <= {NUM_VOICES{1'b0}};
            sample_addr_r <= {(NUM_VOICES*ADDR_WIDTH){1'b0}};
            active_r      <= {NUM_VOICES{1'b0}};
            done_pulse_r  <= {NUM_VOICES{1'b0}};
            led_r         <= 1'b0;
        end else begin
            gate_prev_r <= bus.gate_in;
            active_r    <= active_next_s;
            led_r       <= |active_next_s;
            for (int v = 0; v < NUM_VOICES; v++) begin
                done_pulse_r[v] <= 1'b0;
                if (!bus.gate_in[v]) begin
                    state_r[v]                               <= ST_IDLE;
                    phase_r[v]                               <= {STEP_WIDTH{1'b0}};
                    sample_addr_r[v*ADDR_WIDTH +: ADDR_WIDTH] <= {ADDR_WIDTH{1'b0}};
                end else if (rise_s[v]) begin
                    // Retrigger wins over a coincident tick.
                    state_r[v]                               <= ST_PLAY;
                    phase_r[v]                               <= {win_start_s, FRAC_ZERO};
                    sample_addr_r[v*ADDR_WIDTH +: ADDR_WIDTH] <= win_start_s;
                end else begin
                    case (state_r[v])
                        ST_PLAY: begin
                            if (bus.sample_tick) begin
                                if (!overshoot_s[v]) begin
                                    phase_r[v]                               <= sum_s[v][STEP_WIDTH-1:0];
                                    sample_addr_r[v*ADDR_WIDTH +: ADDR_WIDTH] <= sum_s[v][FRAC_WIDTH +: ADDR_WIDTH];
                                end else if (!bus.mode_in[v]) begin
                                    // Loop: restart at the window start, keep the fraction.
                                    phase_r[v]                               <= {win_start_s, sum_s[v][FRAC_WIDTH-1:0]};
                                    sample_addr_r[v*ADDR_WIDTH +: ADDR_WIDTH] <= win_start_s;
                                end else begin
                                    state_r[v]                               <= ST_DONE;
                                    phase_r[v]                               <= {win_end_s, FRAC_ZERO};
                                    sample_addr_r[v*ADDR_WIDTH +: ADDR_WIDTH] <= win_end_s;
                                    done_pulse_r[v]                          <= 1'b1;
                                end
                            end
                        end
                        ST_DONE: begin
                            state_r[v] <= ST_DONE;
                        end
                        ST_IDLE: begin
                            state_r[v] <= ST_IDLE;
                        end
                        default: begin
                            state_r[v]                               <= ST_IDLE;
                            phase_r[v]                               <= {STEP_WIDTH{1'b0}};
                            sample_addr_r[v*ADDR_WIDTH +: ADDR_WIDTH] <= {ADDR_WIDTH{1'b0}};
                        end
                    endcase
                end
            end
        end
    end

    assign bus.sample_addr    = sample_addr_r;
    assign bus.active_out     = active_r;
    assign bus.done_pulse_out = done_pulse_r;
    assign bus.led            = led_r;

endmodule
